// File: rtl/demultiplexer_stream.sv
// demultiplexer_stream
// ---------------------------------------------------------------------------
// Steers one producer stream to one of two consumer streams. Each branch has
// its own first-word-fall-through FIFO, so a stalled consumer only blocks the
// producer while `sel` points at that consumer's branch.
//
// Optional feature: define DEMUX_COUNT_EN to add two 8-bit wrapping counters
// of accepted bytes per branch (ports out1_count / out2_count).
//
// Parameters
//   WIDTH       data width of the input and both outputs
//   DEPTH       entries per branch FIFO (power of two, >= 2)
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   input_1     input data
//   in_valid    producer has data on input_1
//   in_ready    the branch selected by sel has room (never depends on in_valid)
//   sel         destination: 0 -> output_1, 1 -> output_2
//   output_1    head of branch-1 FIFO, zero while out1_valid is low
//   out1_valid  branch-1 FIFO non-empty
//   out1_ready  branch-1 consumer takes the head entry
//   output_2 / out2_valid / out2_ready   same for branch 2
//   out1_count / out2_count  accepted-byte counters (DEMUX_COUNT_EN only)
// ---------------------------------------------------------------------------
module demultiplexer_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  output logic [WIDTH-1:0] output_1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] output_2,
  output logic             out2_valid,
  input  logic             out2_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [7:0]       out1_count,
  output logic [7:0]       out2_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);

  // Index 0 is branch 1 (output_1), index 1 is branch 2 (output_2).
  logic [1:0]            branch_sel_s;
  logic [1:0]            full_s;
  logic [1:0]            valid_s;
  logic [1:0]            out_ready_s;
  logic [1:0]            push_s;
  logic [1:0]            pop_s;
  logic [1:0][WIDTH-1:0] data_s;
  logic                  in_fire_s;
`ifdef DEMUX_COUNT_EN
  logic [1:0][7:0]       count_s;
`endif

  // Handshake decode: in_ready only looks at sel and FIFO fullness, so there
  // is no path from in_valid or from either out ready into in_ready. A full
  // branch being popped this cycle still reports not-ready.
  always_comb begin
    branch_sel_s = {sel, ~sel};
    out_ready_s  = {out2_ready, out1_ready};
    in_ready     = ~full_s[sel];
    in_fire_s    = in_valid & in_ready;
    push_s       = branch_sel_s & {2{in_fire_s}};
    pop_s        = valid_s & out_ready_s;
  end

  for (genvar b = 0; b < 2; b++) begin : g_branch
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    occ_r;

    // Storage write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
      if (push_s[b] && !reset) begin
        mem_r[wr_ptr_r] <= input_1;
      end
    end

    // Pointers wrap naturally; fullness/emptiness come from occupancy only.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
        occ_r    <= {CW{1'b0}};
      end else begin
        if (push_s[b]) begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
        end
        if (pop_s[b]) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
        case ({push_s[b], pop_s[b]})
          2'b10:   occ_r <= occ_r + CW'(1);
          2'b01:   occ_r <= occ_r - CW'(1);
          default: occ_r <= occ_r;
        endcase
      end
    end

    assign full_s[b]  = (occ_r == OCC_FULL);
    assign valid_s[b] = (occ_r != {CW{1'b0}});
    // Head is gated to zero when empty so stale memory never shows.
    assign data_s[b]  = valid_s[b] ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

`ifdef DEMUX_COUNT_EN
    logic [7:0] count_r;

    // Accepted-byte counter for this branch, wraps 255 -> 0.
    always_ff @(posedge clk) begin
      if (reset) begin
        count_r <= 8'd0;
      end else if (push_s[b]) begin
        count_r <= count_r + 8'd1;
      end
    end

    assign count_s[b] = count_r;
`endif
  end

  assign output_1   = data_s[0];
  assign out1_valid = valid_s[0];
  assign output_2   = data_s[1];
  assign out2_valid = valid_s[1];
`ifdef DEMUX_COUNT_EN
  assign out1_count = count_s[0];
  assign out2_count = count_s[1];
`endif

endmodule

// File: doc/demultiplexer_stream.md
# demultiplexer_stream

Routes one 8-bit producer stream to one of two consumer streams and buffers each branch independently. `sel` chooses the branch per byte. This is the write-side counterpart of the 2:1 operand `Multiplexer`: it sits on a datapath output and steers results to one of two register-file or port destinations. Each branch has its own small FIFO, so a stalled consumer does not block the other branch, except while `sel` points at the stalled branch.

## Interface
- `WIDTH`, default 8: data width of the input and both outputs.
- `DEPTH`, default 2: entries per branch FIFO; must be a power of two and at least 2.

- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `input_1`  in  WIDTH: input data byte.
- `in_valid`  in  1: the producer asserts this when `input_1` holds valid data.
- `in_ready`  out  1: the demux can accept the current byte.
- `sel`  in  1: destination branch; 0 routes to `output_1`, 1 routes to `output_2`. Sampled only on an accepted transfer.
- `output_1`  out  WIDTH: head of branch-1 FIFO.
- `out1_valid`  out  1: branch-1 FIFO is non-empty.
- `out1_ready`  in  1: the branch-1 consumer takes the head entry.
- `output_2`, `out2_valid`, `out2_ready`: same meaning for branch 2.
- `out1_count`, `out2_count`  out  8: per-branch accepted-byte counters. Present only with `DEMUX_COUNT_EN`.

## Operation
- Input accept: `in_fire = in_valid & in_ready`.
- `in_ready` is high when `!full[sel]`. It is combinational from `sel` and the FIFO state only, never from `in_valid`.
- On `in_fire`, `input_1` is written to FIFO[`sel`] at its write pointer, and that write pointer increments mod DEPTH.
- Output pop: `outN_fire = outN_valid & outN_ready`.
  - On a pop, the read pointer increments mod DEPTH.
  - `outN_ready` while `outN_valid` is low is ignored.
- Each FIFO tracks an occupancy counter of width clog2(DEPTH)+1.
  - `full` means occupancy == DEPTH. `empty` means occupancy == 0.
  - On the same cycle, push only adds 1, pop only subtracts 1, and push with pop leaves occupancy unchanged.
- Simultaneous events:
  - A push to one branch and a pop from the other proceed independently.
  - A push and a pop on the same non-full branch both occur. Data order is preserved.
  - A full branch popped this cycle still shows `in_ready` = 0 this cycle. There is no pass-through, so the slot frees one cycle later.
- Outputs are first-word-fall-through: `outN_data` = mem[rd_ptr], held stable while `outN_valid` is high and not popped.
- While `outN_valid` is low, `outN_data` is 0 (gated), never stale memory.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Full and empty are determined by the occupancy counter, not pointer comparison.
- Reset:
  - Pointers and occupancies go to 0, so `outN_valid` = 0 and `outN_data` = 0.
  - `in_ready` = 1 after reset for either `sel`.
  - Counters go to 0.
  - Reset mid-transfer discards all buffered bytes. A byte presented in the reset cycle is not accepted.
  - Memory contents are not reset.

## Timing
- Latency: a byte accepted at edge k appears with `outN_valid` = 1 from edge k onward, i.e. visible in cycle k+1. Minimum one cycle input-to-output.
- Throughput: one byte per cycle per branch sustained when the consumer keeps `outN_ready` high.
- `in_ready` depends combinationally on `sel`. The producer must hold `sel` stable with data while `in_valid` is high and unaccepted.
- No combinational path from `outN_ready` to `in_ready`.

## Configuration
- `DEMUX_COUNT_EN`:
  - Defined: two 8-bit counters each increment on every accepted byte routed to their branch. They wrap from 255 to 0 and are driven on `out1_count` and `out2_count`. They reset to 0.
  - Undefined: the counters and both count ports are absent. All other behaviour is identical.

## Test plan
- Reset: assert `reset` for 2 cycles with `in_valid` = 1 -> `in_ready` = 1, both `outN_valid` = 0, both `outN_data` = 0x00, and nothing is enqueued.
- Routing: push 0xA5 with `sel` = 0, then 0x3C with `sel` = 1, both consumers ready -> `output_1` = 0xA5 one cycle after its push, `output_2` = 0x3C one cycle after its push, no cross-delivery.
- Backpressure and full: `out1_ready` = 0; push 0x11, 0x22 to branch 1.
  - Expect `in_ready` = 0 with `sel` = 0 but 1 with `sel` = 1.
  - A third push on branch 2 (0x33) is accepted.
  - Release `out1_ready`: expect 0x11 then 0x22 in order.
- Full with same-cycle pop: branch 1 full, pop and `in_valid` asserted the same cycle -> no accept that cycle. Accepted next cycle. Occupancy ends at 2.
- Wrap: stream 0x00..0x0F to branch 2 with random `out2_ready` -> output sequence exactly 0x00..0x0F, with pointers wrapping 8 times at DEPTH = 2.
- With `DEMUX_COUNT_EN`: route 257 bytes to branch 1 and 3 to branch 2 -> `out1_count` = 1 (wrapped), `out2_count` = 3. Reset mid-stream -> both read 0.
